// File: rtl/sinewave_pkg.sv
// Shared definitions for the sine-wave serial datapath, so the serializer and
// the deserializer agree on state encodings and the default word length.
package sinewave_pkg;

  localparam int DEFAULT_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LAST  = 2'd2
  } state_t;

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period strobe generator: while run is high, tick fires on the last
// cycle of every DIV-cycle period. Counter is held at zero when not running.
module bit_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] TERM = 8'(DIV - 1);

  logic [7:0] div_cnt;

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      div_cnt <= 8'd0;
    end else if (div_cnt == TERM) begin
      div_cnt <= 8'd0;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

  assign tick = run && (div_cnt == TERM);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: loads a word on load&&ready and shifts
// it out MSB-first, one bit per DIV cycles, with FRAME/SO_en/DONE framing.
module piso_serializer
  import sinewave_pkg::*;
#(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter int   DIV        = 1,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] PDATA,
  input  logic             load,
  output logic             ready,
  output logic             SO,
  output logic             SO_en,
  output logic             FRAME,
  output logic             DONE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Handshake: a word transfers on any rising edge where load && ready.
  // ready is high in IDLE and LAST, low for the whole SHIFT phase.

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             tick;
  logic             load_accept;

  assign load_accept = load && (state != SHIFT);

  bit_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state == SHIFT),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_accept) begin
        sreg    <= PDATA;
        bit_cnt <= CW'(WIDTH - 1);
      end else if ((state == SHIFT) && tick && (bit_cnt != '0)) begin
        sreg    <= sreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b1;
    SO        = IDLE_LEVEL;
    SO_en     = 1'b0;
    FRAME     = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        if (load) state_nxt = SHIFT;
      end
      SHIFT: begin
        ready = 1'b0;
        SO    = sreg[WIDTH-1];
        SO_en = tick;
        FRAME = 1'b1;
        if (tick && (bit_cnt == '0)) state_nxt = LAST;
      end
      LAST: begin
        DONE      = 1'b1;
        state_nxt = load ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: three instances (DIV 1, 3, 4) checked cycle by
// cycle against a frame model derived from word, DIV and cycle index.
module tb_piso_serializer;
  import sinewave_pkg::*;

  localparam int W = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         load_i  [3];
  logic [W-1:0] pdata_i [3];
  logic         ready_o [3];
  logic         so_o    [3];
  logic         so_en_o [3];
  logic         frame_o [3];
  logic         done_o  [3];

  int pass_cnt  = 0;
  int check_cnt = 0;
  logic [W-1:0] exp_q[$];

  piso_serializer #(.WIDTH(W), .DIV(1), .IDLE_LEVEL(1'b1)) u_div1 (
    .clk(clk), .rst(rst), .PDATA(pdata_i[0]), .load(load_i[0]), .ready(ready_o[0]),
    .SO(so_o[0]), .SO_en(so_en_o[0]), .FRAME(frame_o[0]), .DONE(done_o[0]));

  piso_serializer #(.WIDTH(W), .DIV(3), .IDLE_LEVEL(1'b1)) u_div3 (
    .clk(clk), .rst(rst), .PDATA(pdata_i[1]), .load(load_i[1]), .ready(ready_o[1]),
    .SO(so_o[1]), .SO_en(so_en_o[1]), .FRAME(frame_o[1]), .DONE(done_o[1]));

  piso_serializer #(.WIDTH(W), .DIV(4), .IDLE_LEVEL(1'b1)) u_div4 (
    .clk(clk), .rst(rst), .PDATA(pdata_i[2]), .load(load_i[2]), .ready(ready_o[2]),
    .SO(so_o[2]), .SO_en(so_en_o[2]), .FRAME(frame_o[2]), .DONE(done_o[2]));

  function automatic int div_of(int idx);
    case (idx)
      0:       return 1;
      1:       return 3;
      default: return 4;
    endcase
  endfunction

  // {SO, SO_en, FRAME, DONE, ready} for cycle c after the load edge.
  function automatic logic [4:0] model_vec(logic [W-1:0] word, int div, int c);
    logic [4:0] v;
    if (c <= W * div) begin
      v[4] = word[W - 1 - (c - 1) / div];
      v[3] = ((c % div) == 0);
      v[2] = 1'b1;
      v[1] = 1'b0;
      v[0] = 1'b0;
    end else if (c == W * div + 1) begin
      v = 5'b10011;
    end else begin
      v = 5'b10001;
    end
    return v;
  endfunction

  function automatic logic [4:0] obs(int idx);
    return {so_o[idx], so_en_o[idx], frame_o[idx], done_o[idx], ready_o[idx]};
  endfunction

  // Called just after a falling edge; the load is taken at the next rising edge.
  task automatic start_load(int idx, logic [W-1:0] word);
    load_i[idx]  = 1'b1;
    pdata_i[idx] = word;
    exp_q.push_back(word);
    @(posedge clk);
    #1;
    load_i[idx]  = 1'b0;
    pdata_i[idx] = W'($urandom);
  endtask

  // Walks one frame through its DONE cycle; junk_c>0 pulses a load of 12'hFFF
  // during that cycle. A receiver is modelled by capturing SO on SO_en.
  task automatic run_frame(int idx, logic [W-1:0] word, string name, int junk_c);
    int           div = div_of(idx);
    logic [W-1:0] rx  = '1;
    logic [W-1:0] want;
    logic [4:0]   e;
    logic [4:0]   g;
    for (int c = 1; c <= W * div + 1; c++) begin
      @(negedge clk);
      e = model_vec(word, div, c);
      g = obs(idx);
      check_cnt++;
      if (g !== e) $display("FAIL %s cycle %0d: got SO/en/FRAME/DONE/ready=%b want %b", name, c, g, e);
      else pass_cnt++;
      if (so_en_o[idx] === 1'b1) rx = {rx[W-2:0], so_o[idx]};
      if (c == W * div + 1) begin
        load_i[idx] = 1'b0;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : ~rx;
        check_cnt++;
        if (rx !== want) $display("FAIL %s rx_word: got %h want %h", name, rx, want);
        else pass_cnt++;
      end else begin
        pdata_i[idx] = (c == junk_c) ? 12'hFFF : W'($urandom);
        load_i[idx]  = (c == junk_c);
      end
    end
  endtask

  task automatic test_idle(int idx, int n, string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_cnt++;
      if (obs(idx) !== 5'b10001) $display("FAIL %s idle %0d: got %b want 10001", name, i, obs(idx));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_i[i]  = 1'b1;
      pdata_i[i] = W'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_cnt++;
      if (obs(i) !== 5'b10001) $display("FAIL reset inst %0d: got %b want 10001", i, obs(i));
      else pass_cnt++;
      load_i[i] = 1'b0;
    end
    rst = 1'b0;
    test_idle(0, 2, "post_reset");
  endtask

  task automatic test_div1_a5c();
    start_load(0, 12'hA5C);
    run_frame(0, 12'hA5C, "div1_a5c", 0);
    test_idle(0, 2, "div1_a5c_after");
  endtask

  task automatic test_div4_801();
    start_load(2, 12'h801);
    run_frame(2, 12'h801, "div4_801", 0);
    test_idle(2, 2, "div4_801_after");
  endtask

  task automatic test_ignore_load();
    start_load(0, 12'h123);
    run_frame(0, 12'h123, "ignore_load", 5);
    test_idle(0, 4, "ignore_load_after");
  endtask

  task automatic test_reset_mid_frame();
    logic [W-1:0] w = W'($urandom);
    logic [W-1:0] dropped;
    start_load(0, w);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      check_cnt++;
      if (obs(0) !== model_vec(w, 1, c)) $display("FAIL reset_mid cycle %0d: got %b want %b", c, obs(0), model_vec(w, 1, c));
      else pass_cnt++;
      load_i[0] = (c == 6);
      rst       = (c == 6);
    end
    dropped = exp_q.pop_front();
    @(negedge clk);
    check_cnt++;
    if (obs(0) !== 5'b10001) $display("FAIL reset_mid cycle 7: got %b want 10001 (word %h)", obs(0), dropped);
    else pass_cnt++;
    rst       = 1'b0;
    load_i[0] = 1'b0;
    test_idle(0, 15, "reset_mid_no_done");
  endtask

  task automatic test_back_to_back();
    start_load(0, 12'h0F0);
    run_frame(0, 12'h0F0, "b2b_first", 0);
    start_load(0, 12'h3C3);
    run_frame(0, 12'h3C3, "b2b_second", 0);
    test_idle(0, 2, "b2b_after");
  endtask

  task automatic test_loopback(int idx);
    logic [W-1:0] w;
    for (int n = 0; n < 100; n++) begin
      w = W'($urandom);
      start_load(idx, w);
      run_frame(idx, w, (idx == 0) ? "loop_div1" : "loop_div3", 0);
      if ($urandom_range(1, 0) == 1) test_idle(idx, $urandom_range(3, 1), "loop_gap");
    end
    test_idle(idx, 1, "loop_end");
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load_i[i]  = 1'b0;
      pdata_i[i] = '0;
    end
    test_reset();
    test_div1_a5c();
    test_div4_801();
    test_ignore_load();
    test_reset_mid_frame();
    test_back_to_back();
    test_loopback(0);
    test_loopback(1);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parallel-in serial-out transmitter and the counterpart of SIPO_ShiftRegister in the sine-wave datapath. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB-first on SO, one bit per DIV clock cycles. SO_en is a per-bit strobe that drives a receiver's SI_en directly, so a SIPO_ShiftRegister clocked from the same clk captures exactly WIDTH bits per frame. FRAME brackets the transfer, and DONE marks its end.

Parameters:
WIDTH, 12, word length in bits (frame length).
DIV, 1, clock cycles per bit (1 to 255); 1 gives one bit per clock.
IDLE_LEVEL, 1'b1, value driven on SO outside a frame.

Ports:
clk  in  1  system clock (100 MHz in the sine-wave design)
rst  in  1  synchronous active-high reset
PDATA  in  WIDTH  parallel word to transmit
load  in  1  load request, qualified by ready
ready  out  1  high when a load is accepted this cycle
SO  out  1  serial data, MSB first
SO_en  out  1  one-cycle strobe on the last cycle of each bit period
FRAME  out  1  high for the whole bit stream (WIDTH*DIV cycles)
DONE  out  1  one-cycle pulse after the last bit period

Behaviour:
- Reset: rst is sampled on the rising clk edge and overrides all other inputs.
  - At the edge after rst: state=IDLE, SO=IDLE_LEVEL, SO_en=0, FRAME=0, DONE=0, ready=1, shift register=0, counters=0.
  - Reset asserted mid-frame aborts the frame at the next edge: no DONE, and SO returns to IDLE_LEVEL.
- States: IDLE, SHIFT, LAST.
  - IDLE: ready=1. If load=1 at edge k, latch PDATA, set bit_cnt=WIDTH-1 and div_cnt=0, go to SHIFT. From cycle k+1: FRAME=1 and SO=PDATA[WIDTH-1].
  - SHIFT: div_cnt increments each cycle.
    - When div_cnt==DIV-1: SO_en=1 that cycle and div_cnt wraps to 0.
    - If bit_cnt!=0: shift left, SO takes the next bit, bit_cnt decrements.
    - If bit_cnt==0: go to LAST.
  - LAST: lasts one cycle. DONE=1, FRAME=0, SO=IDLE_LEVEL, ready=1, SO_en=0.
    - load in LAST is accepted exactly as in IDLE, which allows back-to-back frames with a one-cycle gap.
    - Otherwise go to IDLE.
- Timing:
  - FRAME is high for exactly WIDTH*DIV cycles.
  - SO_en fires exactly WIDTH times per frame, on cycles k+DIV, k+2*DIV, …, k+WIDTH*DIV.
  - DONE occurs on cycle k+WIDTH*DIV+1.
- ready=0 throughout SHIFT. A load during SHIFT is ignored and not queued, and PDATA changes during SHIFT have no effect.
- SO changes only at bit-period boundaries and is stable whenever SO_en=1.
- DIV=1: SO_en=1 on every FRAME cycle.
- bit_cnt width is clog2(WIDTH); div_cnt is 8 bits. Both wrap without overflow because of the terminal compares.
- load and rst in the same cycle: rst wins.

Decomposition:
- Shared package sinewave_pkg holds the state encodings (IDLE=2'd0, SHIFT=2'd1, LAST=2'd2) and the default WIDTH=12, so SIPO and PISO agree.
- One natural sub-module, bit_tick_gen (params DIV; ports clk, rst, run, tick), generates the bit-period strobe that serves as SO_en. The serializer FSM and shift register stay in the top module.

Test Plan:
- WIDTH=12, DIV=1, load PDATA=12'hA5C at edge 0:
  - SO on cycles 1–12 is 1,0,1,0,0,1,0,1,1,1,0,0.
  - SO_en=1 on cycles 1–12, FRAME=1 on cycles 1–12.
  - DONE=1 on cycle 13 only, then SO=1 (IDLE_LEVEL).
- DIV=4, load 12'h801:
  - Each bit is held 4 cycles, SO_en pulses on cycles 4, 8, …, 48 (12 pulses).
  - FRAME is 48 cycles, DONE on cycle 49.
- Load 12'h123, then pulse load with PDATA=12'hFFF at cycle 5:
  - ready=0 and the second load is ignored.
  - The stream remains 0001_0010_0011, and exactly one DONE is produced.
- rst=1 at cycle 6 of a DIV=1 frame: from cycle 7, SO=1, FRAME=0, SO_en=0, ready=1, and no DONE.
- Back-to-back: load 12'h0F0, then load 12'h3C3 in the DONE cycle. The second frame's FRAME rises one cycle after DONE and the streams are bit-exact.
- Loopback: SO→SI and SO_en→SI_en into SIPO_ShiftRegister (N=11, INIT=12'hFFF). 100 random words at DIV 1 and 3 each yield PDATA equal to the sent word at DONE.
